// File: rtl/key_word_sub_unit.sv
// key_word_sub_unit: AES key-schedule word transform (optional RotWord, SubWord, Rcon XOR)
// with ready/valid handshakes on both sides and LANES S-box lookups per cycle.
// Build option: define KWS_AUTO_RCON_EN to use the internal Rcon sequence instead of rcon_in.
// The per-lane ROM contents are derived from the S-box arithmetic (GF(2^8) inverse plus affine
// map), so no image file has to be shipped; INIT_FILE is kept so existing instantiations still fit.
//
// state | meaning
// IDLE  | ready_out=1, waiting for a word
// ISSUE | present ROM addresses for batch k, one batch per cycle
// DRAIN | wait for the last batch's ROM data to land in its byte slots
// DONE  | result_out valid, held until ready_in
module key_word_sub_unit #(
    parameter int    WORD_BYTES = 4,
    parameter int    LANES      = 1,
    parameter string INIT_FILE  = "byte_sub_table.mem"
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [WORD_BYTES*8-1:0] word_in,
    input  logic                    rot_en_in,
    input  logic [7:0]              rcon_in,
    input  logic                    rcon_restart_in,
    output logic [WORD_BYTES*8-1:0] result_out,
    output logic                    valid_out,
    input  logic                    ready_in
);

    localparam int W  = WORD_BYTES * 8;
    localparam int B  = WORD_BYTES / LANES;
    localparam int BW = (B > 1) ? $clog2(B) : 1;
    localparam logic [BW-1:0] LAST_BATCH = BW'(B - 1);

    if (WORD_BYTES % LANES != 0) begin : g_lanes_check
        $error("key_word_sub_unit: LANES must divide WORD_BYTES");
    end
    if (INIT_FILE == "") begin : g_image_check
        $error("key_word_sub_unit: INIT_FILE must name the S-box image");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse is a^254 (0 maps to 0), followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    state_t        state;
    logic [BW-1:0] batch;
    logic [W-1:0]  word_q;
    logic [W-1:0]  sub_q;
    logic [7:0]    rcon_q;
    logic [7:0]    rcon_sel;
    logic          tag1_vld;
    logic          tag2_vld;
    logic [BW-1:0] tag1_idx;
    logic [BW-1:0] tag2_idx;
    logic [7:0]    rom_addr [LANES];
    logic [7:0]    rom_data [LANES];
    logic          accept;
    logic [W-1:0]  rot_word;

    assign accept   = valid_in && ready_out;
    assign rot_word = rot_en_in ? {word_in[W-9:0], word_in[W-1:W-8]} : word_in;

`ifdef KWS_AUTO_RCON_EN
    logic [7:0] rcon_auto;
    logic [7:0] unused_rcon_in;

    assign unused_rcon_in = rcon_in;
    // Non-rotated steps carry no round constant.
    assign rcon_sel = rot_en_in ? rcon_auto : 8'h00;

    // Internal Rcon sequence: restart wins; otherwise advance after each rotated accept.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rcon_auto <= 8'h01;
        end else if (rcon_restart_in) begin
            rcon_auto <= 8'h01;
        end else if (accept && rot_en_in) begin
            rcon_auto <= xtime(rcon_auto);
        end
    end
`else
    logic unused_restart;

    assign unused_restart = rcon_restart_in;
    assign rcon_sel       = rcon_in;
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            ready_out  <= 1'b1;
            valid_out  <= 1'b0;
            result_out <= '0;
            batch      <= '0;
            word_q     <= '0;
            rcon_q     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        word_q    <= rot_word;
                        rcon_q    <= rcon_sel;
                        batch     <= '0;
                        ready_out <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (batch == LAST_BATCH) begin
                        state <= DRAIN;
                    end else begin
                        batch <= batch + BW'(1);
                    end
                end
                DRAIN: begin
                    if (!tag1_vld && !tag2_vld) begin
                        result_out <= sub_q ^ {rcon_q, {(W-8){1'b0}}};
                        valid_out  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        ready_out <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Two-deep batch-index pipeline tracking the ROM latency; writes returning bytes into their slots.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tag1_vld <= 1'b0;
            tag2_vld <= 1'b0;
            tag1_idx <= '0;
            tag2_idx <= '0;
            sub_q    <= '0;
        end else begin
            tag1_vld <= (state == ISSUE);
            tag1_idx <= batch;
            tag2_vld <= tag1_vld;
            tag2_idx <= tag1_idx;
            if (tag2_vld) begin
                for (int l = 0; l < LANES; l++) begin
                    sub_q[(int'(tag2_idx) * LANES + l) * 8 +: 8] <= rom_data[l];
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        // Per-lane S-box ROM: registered address, registered data.
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                rom_addr[l] <= 8'h00;
                rom_data[l] <= 8'h00;
            end else begin
                if (state == ISSUE) begin
                    rom_addr[l] <= word_q[(int'(batch) * LANES + l) * 8 +: 8];
                end
                rom_data[l] <= sbox(rom_addr[l]);
            end
        end
    end

endmodule

// File: tb/tb_key_word_sub_unit.sv
// Directed bench for key_word_sub_unit: three instances (LANES 1, 2, 4) share the inputs.
// With KWS_AUTO_RCON_EN defined, the internal Rcon sequence is exercised as well.
module tb_key_word_sub_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        rot_en;
    logic        ready_in;
    logic        rcon_restart;
    logic [31:0] word;
    logic [7:0]  rcon;
    logic        rdy [3];
    logic        vld [3];
    logic [31:0] res [3];
    int          lat [3];
    logic [31:0] got [3];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    key_word_sub_unit #(.WORD_BYTES(4), .LANES(1)) u_l1 (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(rdy[0]),
        .word_in(word), .rot_en_in(rot_en), .rcon_in(rcon), .rcon_restart_in(rcon_restart),
        .result_out(res[0]), .valid_out(vld[0]), .ready_in(ready_in));

    key_word_sub_unit #(.WORD_BYTES(4), .LANES(2)) u_l2 (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(rdy[1]),
        .word_in(word), .rot_en_in(rot_en), .rcon_in(rcon), .rcon_restart_in(rcon_restart),
        .result_out(res[1]), .valid_out(vld[1]), .ready_in(ready_in));

    key_word_sub_unit #(.WORD_BYTES(4), .LANES(4)) u_l4 (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(rdy[2]),
        .word_in(word), .rot_en_in(rot_en), .rcon_in(rcon), .rcon_restart_in(rcon_restart),
        .result_out(res[2]), .valid_out(vld[2]), .ready_in(ready_in));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Send one word (ready_in assumed high) and record each instance's latency and result.
    task automatic run_word(input logic [31:0] w, input logic r, input logic [7:0] rc);
        bit seen [3];
        @(negedge clk);
        word = w; rot_en = r; rcon = rc; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen[i] = 1'b0; lat[i] = 0; got[i] = 'x;
        end
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!seen[i] && vld[i]) begin
                    seen[i] = 1'b1; lat[i] = n; got[i] = res[i];
                end
            end
        end
    endtask

    task automatic pulse_restart();
        @(negedge clk); rcon_restart = 1'b1;
        @(negedge clk); rcon_restart = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_rc [10];
        int n;
        exp_rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        rst_n = 1'b0; valid_in = 1'b0; rot_en = 1'b0; rcon = 8'h00;
        ready_in = 1'b1; rcon_restart = 1'b0; word = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_valid_%0d", i), 32'(vld[i]), 32'd0);
            chk($sformatf("reset_result_%0d", i), res[i], 32'h0);
            chk($sformatf("reset_ready_%0d", i), 32'(rdy[i]), 32'd1);
        end
        rst_n = 1'b1;

        // AES-128 first step, with per-lane-count latency
        run_word(32'h09cf4f3c, 1'b1, 8'h01);
        for (int i = 0; i < 3; i++) chk($sformatf("aes_result_%0d", i), got[i], 32'h8b84eb01);
        chk("aes_latency_l1", 32'(lat[0]), 32'd7);
        chk("aes_latency_l2", 32'(lat[1]), 32'd5);
        chk("aes_latency_l4", 32'(lat[2]), 32'd4);

        // No rotate, no Rcon
        run_word(32'h00010203, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) chk($sformatf("norot_result_%0d", i), got[i], 32'h637c777b);

        // Backpressure with junk valid_in pulses while busy
        pulse_restart();
        ready_in = 1'b0;
        @(negedge clk);
        word = 32'h09cf4f3c; rot_en = 1'b1; rcon = 8'h01; valid_in = 1'b1;
        @(posedge clk);
        #1 word = 32'hffffffff; rot_en = 1'b0; rcon = 8'h5a;
        chk("busy_ready", 32'(rdy[0]), 32'd0);
        n = 0;
        while (!vld[0] && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk("bp_valid_rise", 32'(vld[0]), 32'd1);
        chk("bp_latency", 32'(n), 32'd7);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(vld[0]), 32'd1);
            chk("bp_hold_result", res[0], 32'h8b84eb01);
            chk("bp_hold_result_l4", res[2], 32'h8b84eb01);
            chk("bp_busy_ready", 32'(rdy[0]), 32'd0);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(vld[0]), 32'd0);
        chk("bp_release_ready", 32'(rdy[0]), 32'd1);
        chk("bp_result_kept", res[0], 32'h8b84eb01);
        run_word(32'h00010203, 1'b0, 8'h00);
        chk("after_bp_result", got[0], 32'h637c777b);
        chk("after_bp_latency", 32'(lat[0]), 32'd7);

        // Reset while LANES=1 instance is in DRAIN; LANES=4 instance is holding DONE
        ready_in = 1'b0;
        @(negedge clk);
        word = 32'h09cf4f3c; rot_en = 1'b1; rcon = 8'h01; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 32'(rdy[0]), 32'd0);
        chk("pre_reset_l4_valid", 32'(vld[2]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid_l1", 32'(vld[0]), 32'd0);
        chk("mid_reset_valid_l4", 32'(vld[2]), 32'd0);
        chk("mid_reset_result_l1", res[0], 32'h0);
        chk("mid_reset_result_l4", res[2], 32'h0);
        chk("mid_reset_ready_l1", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ready_in = 1'b1;
        run_word(32'h00010203, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) chk($sformatf("post_reset_result_%0d", i), got[i], 32'h637c777b);

`ifdef KWS_AUTO_RCON_EN
        for (int i = 0; i < 10; i++) begin
            run_word(32'h0, 1'b1, 8'hff);
            chk($sformatf("auto_rcon_%0d", i), got[0], {8'h63 ^ exp_rc[i], 24'h636363});
        end
        pulse_restart();
        run_word(32'h0, 1'b1, 8'hff);
        chk("auto_restart", got[0], 32'h62636363);
        run_word(32'h0, 1'b0, 8'hff);
        chk("auto_norot_zero", got[0], 32'h63636363);
        run_word(32'h0, 1'b1, 8'hff);
        chk("auto_norot_no_advance", got[0], 32'h61636363);
`else
        pulse_restart();
        run_word(32'h0, 1'b1, exp_rc[9]);
        chk("rcon_in_36", got[0], 32'h55636363);
        chk("rcon_in_36_l4", got[2], 32'h55636363);
        run_word(32'h00010203, 1'b0, 8'h80);
        chk("rcon_in_80", got[0], 32'he37c777b);
        chk("rcon_in_80_l2", got[1], 32'he37c777b);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
